image_scaler_feeder: RTL
========================

Name: image_scaler_feeder

Overview:
- Drives the image_scaler pixel interface from a serial source-pixel stream and collects its Tpix results.
- Keeps a 5-tap source window (B4..B0) and a 3-deep target-pixel history (T1..T3), and sequences UPS scaler evaluations per source pixel.
- Emits the scaled line as a valid/ready stream.
- Sits between the line-stream source and the combinational image_scaler. The scaler is external, wired to the win_*/tpix ports.

Parameters:
- DW, 8: pixel width in bits.
- UPS, 2: target pixels produced per source pixel (upscale factor), range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  source pixel valid.
- in_ready  out  1  block accepts a source pixel this cycle.
- in_data  in  DW  source pixel.
- in_sol  in  1  start-of-line flag, qualified by in_valid.
- in_eol  in  1  end-of-line flag, qualified by in_valid.
- win_b4, win_b3, win_b2, win_b1, win_b0  out  DW each  source window to scaler. b4 is oldest, b0 newest, b2 is the centre.
- win_t1, win_t2, win_t3  out  DW each  target history to scaler. t1 is most recent.
- tpix  in  DW  scaler result (combinational from win_*).
- out_valid  out  1  scaled pixel valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DW  scaled pixel.
- out_eol  out  1  last scaled pixel of the line.
- err  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset (async, immediate): state=IDLE; win_* = 0; out_valid = 0; out_data = 0; out_eol = 0; err = 0; counters = 0.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_valid/out_data/out_eol hold stable until transferred.
- Capture:
  - A capture latches tpix into out_data and sets out_valid.
  - It also shifts the history: t3<=t2, t2<=t1, t1<=tpix.
  - Capture is allowed only when the output slot is free (!out_valid || out_ready). Same-cycle drain and refill gives full throughput.
  - The scaler is combinational, so the window presented in a cycle is captured at that cycle's edge.
- in_ready = 1 only in IDLE, FILL and RUN.
- States and transitions:
  - IDLE: waits for a pixel with in_sol. Non-sol pixels are accepted and dropped. On sol pixel p0: win_b4..b0 <= p0, t1..t3 <= p0, skip <= 2, go to FILL.
  - FILL: each accepted pixel shifts the window (b4<=b3 .. b0<=in_data) and decrements skip. At skip 0 go to EMIT.
    - After p2 the window is p0,p0,p0,p1,p2 (centre p0, left edge replicated).
    - Exception: eol while still in FILL means line shorter than 3. The line is discarded, no output, go to IDLE.
  - RUN: each accepted pixel shifts the window, then go to EMIT. Record eol in a flag.
  - EMIT: perform exactly UPS captures on the current window (phase counter 0..UPS-1; a capture stalls while the slot is busy). Window is frozen.
    - After the last capture: go to FLUSH if eol is flagged, else RUN.
  - FLUSH: perform 2 replicate shifts (b0 <= b0, others shift), each followed by UPS captures. This gives a replicated right edge.
    - out_eol is set on the final capture of the second shift; then go to IDLE and clear the eol flag.
- Output count: a line of N >= 3 source pixels yields exactly N*UPS output pixels, centres in order p0..p(N-1).
- sol in RUN/EMIT/FLUSH: in RUN the pixel starts a new line (reload as in IDLE). The unfinished line is abandoned with no out_eol; a pending out_valid is still delivered.
- in_eol together with in_sol on one pixel counts as a line shorter than 3: discarded.
- Reset mid-line: all state cleared; any pending output is lost.

Optional Feature:
- Macro: IMAGE_SCALER_FEEDER_PROTO_CHECK_EN.
- Defined: err is set (sticky until rst) on any of:
  - a sol pixel arriving in RUN (line restart);
  - an eol pixel in FILL (short line);
  - a non-sol pixel dropped in IDLE.
- Undefined: err is tied 0. Functional behaviour is identical either way.

Test Plan:
- Bench stub tpix = win_b2, UPS=2, out_ready=1. Line 10,20,30,40 (sol on 10, eol on 40) -> outputs 10,10,20,20,30,30,40,40; out_eol only on the last 40; at first capture window = 10,10,10,20,30.
- Same line, stub tpix = win_t1 + 1 -> outputs 11,12,13,...,18 (history chaining; t1 seeded with p0=10).
- out_ready toggling 1/0 each cycle, line 5,6,7 -> same 6 outputs 5,5,6,6,7,7 in order, none duplicated or lost; out_data stable while stalled; in_ready low during EMIT/FLUSH.
- Short line 9,8 (eol on 8) -> no output, back to IDLE; err=1 with macro, 0 without; then line 1,2,3 -> 1,1,2,2,3,3.
- sol pixel 50 mid-line after 10,20,30,40 (no eol) -> old line abandoned without out_eol; line 50,60,70(eol) -> 50,50,60,60,70,70; err=1 with macro.
- Assert rst for one cycle during FLUSH -> outputs immediately 0, out_valid=0, in_ready=1 next cycle; next line processes normally.

Source files
------------

// File: rtl/image_scaler_feeder.sv
// image_scaler_feeder: feeds source window / target history to an external
// combinational image_scaler. Optional err flag: IMAGE_SCALER_FEEDER_PROTO_CHECK_EN.
module image_scaler_feeder #(
  parameter int DW  = 8,
  parameter int UPS = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_sol,
  input  logic          in_eol,
  output logic [DW-1:0] win_b4,
  output logic [DW-1:0] win_b3,
  output logic [DW-1:0] win_b2,
  output logic [DW-1:0] win_b1,
  output logic [DW-1:0] win_b0,
  output logic [DW-1:0] win_t1,
  output logic [DW-1:0] win_t2,
  output logic [DW-1:0] win_t3,
  input  logic [DW-1:0] tpix,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_eol,
  output logic          err
);

`ifdef IMAGE_SCALER_FEEDER_PROTO_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  localparam logic [3:0] LAST = 4'(UPS - 1);

  typedef enum logic [2:0] {IDLE, FILL, RUN, EMIT, FLUSH} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] b_q [5];
  logic [DW-1:0] b_d [5];
  logic [DW-1:0] t_q [3];
  logic [DW-1:0] t_d [3];
  logic [1:0]    skip_q, skip_d;
  logic [3:0]    ph_q, ph_d;
  logic          fl_q, fl_d;
  logic          eol_q, eol_d;
  logic          ov_q, ov_d;
  logic          oe_q, oe_d;
  logic [DW-1:0] od_q, od_d;
  logic          err_q, err_d;
  logic          in_acc, slot_free, cap, cap_last, err_set;

  assign in_ready  = (state_q == IDLE) || (state_q == FILL) ||
                     (state_q == RUN);
  assign in_acc    = in_valid && in_ready;
  assign slot_free = !ov_q || out_ready;

  assign win_b4    = b_q[4];
  assign win_b3    = b_q[3];
  assign win_b2    = b_q[2];
  assign win_b1    = b_q[1];
  assign win_b0    = b_q[0];
  assign win_t1    = t_q[0];
  assign win_t2    = t_q[1];
  assign win_t3    = t_q[2];
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_eol   = oe_q;
  assign err       = PCHK ? err_q : 1'b0;

  // Next-state: window sequencing, capture scheduling and output slot.
  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    t_d      = t_q;
    skip_d   = skip_q;
    ph_d     = ph_q;
    fl_d     = fl_q;
    eol_d    = eol_q;
    ov_d     = ov_q;
    oe_d     = oe_q;
    od_d     = od_q;
    cap      = 1'b0;
    cap_last = 1'b0;
    err_set  = 1'b0;
    if (ov_q && out_ready) begin
      ov_d = 1'b0;
      oe_d = 1'b0;
    end
    unique case (state_q)
      IDLE, FILL, RUN: begin
        if (in_acc) begin
          if (in_sol && in_eol) begin
            state_d = IDLE;
            err_set = 1'b1;
          end else if (in_sol) begin
            for (int i = 0; i < 5; i++) b_d[i] = in_data;
            for (int i = 0; i < 3; i++) t_d[i] = in_data;
            skip_d  = 2'd2;
            ph_d    = '0;
            fl_d    = 1'b0;
            eol_d   = 1'b0;
            state_d = FILL;
            err_set = (state_q == RUN);
          end else if (state_q == IDLE) begin
            err_set = 1'b1;
          end else if (state_q == FILL && in_eol && skip_q == 2'd2) begin
            state_d = IDLE;
            err_set = 1'b1;
          end else begin
            for (int i = 4; i > 0; i--) b_d[i] = b_q[i-1];
            b_d[0] = in_data;
            if (state_q == RUN) begin
              eol_d   = in_eol;
              state_d = EMIT;
            end else begin
              skip_d = skip_q - 2'd1;
              if (skip_q == 2'd1) begin
                eol_d   = in_eol;
                state_d = EMIT;
              end
            end
          end
        end
      end
      EMIT, FLUSH: begin
        if (slot_free) begin
          cap  = 1'b1;
          ph_d = ph_q + 4'd1;
          if (ph_q == LAST) begin
            ph_d = '0;
            if (state_q == FLUSH && fl_q) begin
              cap_last = 1'b1;
              fl_d     = 1'b0;
              eol_d    = 1'b0;
              state_d  = IDLE;
            end else if (state_q == EMIT && !eol_q) begin
              state_d = RUN;
            end else begin
              for (int i = 4; i > 0; i--) b_d[i] = b_q[i-1];
              fl_d    = (state_q == FLUSH);
              state_d = FLUSH;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (cap) begin
      od_d   = tpix;
      ov_d   = 1'b1;
      oe_d   = cap_last;
      t_d[2] = t_q[1];
      t_d[1] = t_q[0];
      t_d[0] = tpix;
    end
    err_d = PCHK & (err_q | err_set);
  end

  // State registers with immediate asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < 5; i++) b_q[i] <= '0;
      for (int i = 0; i < 3; i++) t_q[i] <= '0;
      skip_q  <= '0;
      ph_q    <= '0;
      fl_q    <= 1'b0;
      eol_q   <= 1'b0;
      ov_q    <= 1'b0;
      oe_q    <= 1'b0;
      od_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      t_q     <= t_d;
      skip_q  <= skip_d;
      ph_q    <= ph_d;
      fl_q    <= fl_d;
      eol_q   <= eol_d;
      ov_q    <= ov_d;
      oe_q    <= oe_d;
      od_q    <= od_d;
      err_q   <= err_d;
    end
  end

endmodule
